// File: rtl/lmm_host_driver_pkg.sv
// Shared constants for the large-matrix-multiplier host driver: FSM encoding,
// default geometry and row/counter width helpers.
package lmm_host_driver_pkg;

    localparam int WIDTH_DEF        = 8;
    localparam int NUM_ELEMENTS_DEF = 4;
    localparam int MATRIX_WIDTH_DEF = 4;

    localparam int ROW_BITS = NUM_ELEMENTS_DEF * WIDTH_DEF;
    localparam int CNT_BITS = $clog2(MATRIX_WIDTH_DEF + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // Counter must hold the value MATRIX_WIDTH itself (drain terminal count).
    function automatic int cnt_bits(input int matrix_width);
        return $clog2(matrix_width + 1);
    endfunction

endpackage

// File: rtl/lmm_host_driver_result_skid.sv
// Single-entry valid/ready result register with a last-row flag.
// A load and a downstream accept in the same cycle reload back-to-back.
module lmm_result_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load_vld,
    input  logic [DW-1:0] i_load_dat,
    input  logic          i_load_last,
    input  logic          i_out_rdy,
    output logic [DW-1:0] o_dat,
    output logic          o_vld,
    output logic          o_last
);

    logic [DW-1:0] r_dat;
    logic          r_vld;
    logic          r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (i_load_vld) begin
            r_dat  <= i_load_dat;
            r_vld  <= 1'b1;
            r_last <= i_load_last;
        end else if (r_vld && i_out_rdy) begin
            // Data is left in place; only the qualifiers drop.
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end
    end

    assign o_dat  = r_dat;
    assign o_vld  = r_vld;
    assign o_last = r_last;

endmodule

// File: rtl/lmm_host_driver.sv
// Host-side initiator: streams A then B rows into the multiplier write port,
// then drains MATRIX_WIDTH result rows through a registered valid/ready output.
module lmm_host_driver
    import lmm_host_driver_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
    parameter int MATRIX_WIDTH = MATRIX_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic [NUM_ELEMENTS*WIDTH-1:0]   src_data,
    input  logic                            src_valid,
    output logic                            src_ready,
    output logic [NUM_ELEMENTS*WIDTH-1:0]   mm_wdata,
    output logic                            mm_write_en,
    input  logic                            mm_write_ready,
    input  logic [NUM_ELEMENTS*WIDTH-1:0]   mm_rdata,
    output logic                            mm_read_en,
    input  logic                            mm_read_ready,
    output logic [NUM_ELEMENTS*WIDTH-1:0]   res_data,
    output logic                            res_valid,
    output logic                            res_last,
    input  logic                            res_ready
);

    localparam int ROW_W = NUM_ELEMENTS * WIDTH;
    localparam int CNT_W = cnt_bits(MATRIX_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MATRIX_WIDTH - 1);
    localparam logic [CNT_W-1:0] NUM_ROWS = CNT_W'(MATRIX_WIDTH);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_busy;
    logic             r_done;

    logic w_loading;
    logic w_wr_xfer;
    logic w_rd_xfer;
    logic w_res_acc;
    logic w_res_vld;
    logic w_res_last;

    assign w_loading   = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign mm_write_en = w_loading && src_valid;
    assign src_ready   = w_loading && mm_write_ready;
    // Zero outside the load phases so the port is quiet in IDLE and after reset.
    assign mm_wdata    = w_loading ? src_data : '0;
    assign w_wr_xfer   = mm_write_en && mm_write_ready;

    assign mm_read_en  = (r_state == ST_DRAIN) && (r_rd_cnt < NUM_ROWS) &&
                         (!w_res_vld || res_ready);
    assign w_rd_xfer   = mm_read_en && mm_read_ready;
    assign w_res_acc   = w_res_vld && res_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_LOAD_A;
            ST_LOAD_A: if (w_wr_xfer && r_wr_cnt == LAST_ROW) w_state_nxt = ST_LOAD_B;
            ST_LOAD_B: if (w_wr_xfer && r_wr_cnt == LAST_ROW) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_res_acc && w_res_last) w_state_nxt = ST_FIN;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_LOAD_A) || (w_state_nxt == ST_LOAD_B) ||
                       (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_FIN);

            if (w_state_nxt != r_state) begin
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_wr_xfer) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_rd_xfer) r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    lmm_result_skid #(
        .DW (ROW_W)
    ) u_result_skid (
        .clk         (clk),
        .reset       (reset),
        .i_load_vld  (w_rd_xfer),
        .i_load_dat  (mm_rdata),
        .i_load_last (r_rd_cnt == LAST_ROW),
        .i_out_rdy   (res_ready),
        .o_dat       (res_data),
        .o_vld       (w_res_vld),
        .o_last      (w_res_last)
    );

    assign res_valid = w_res_vld;
    assign res_last  = w_res_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/lmm_host_driver.md
Name: lmm_host_driver

Overview:
Host-side initiator for the large matrix multiplier's write/read port pair. On a start pulse it streams matrix A rows, then matrix B rows, from an upstream row source into the multiplier's write port. It then drains the MATRIX_WIDTH result rows from the multiplier's read port into a registered valid/ready output with a last-row flag. It sits between the host/DMA row stream and the multiplier, on the multiplier's single clock.

Parameters:
WIDTH, 8, bits per matrix element
NUM_ELEMENTS, 4, elements per row word
MATRIX_WIDTH, 4, rows per matrix (A, B and result are each MATRIX_WIDTH rows)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request to begin a multiply job
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse after the last result row is accepted downstream
src_data  input  NUM_ELEMENTS*WIDTH  upstream row (A rows first, then B rows)
src_valid  input  1  upstream row valid
src_ready  output  1  row accepted when src_valid && src_ready
mm_wdata  output  NUM_ELEMENTS*WIDTH  to multiplier wdata
mm_write_en  output  1  to multiplier write_en
mm_write_ready  input  1  from multiplier write_ready
mm_rdata  input  NUM_ELEMENTS*WIDTH  from multiplier Res
mm_read_en  output  1  to multiplier read_en
mm_read_ready  input  1  from multiplier read_ready
res_data  output  NUM_ELEMENTS*WIDTH  registered result row
res_valid  output  1  result row valid
res_last  output  1  qualifies the final result row (row MATRIX_WIDTH-1)
res_ready  input  1  downstream accepts when res_valid && res_ready

Behaviour:
- Reset: synchronous and active-high; all outputs 0, state IDLE, counters 0. Reset mid-job aborts immediately; no partial done pulse.
- States: IDLE, LOAD_A, LOAD_B, DRAIN, FIN.
- IDLE: start -> LOAD_A. start is ignored in every other state.
- Write transfer occurs when mm_write_en && mm_write_ready.
  - mm_write_en = (LOAD_A|LOAD_B) && src_valid.
  - src_ready = (LOAD_A|LOAD_B) && mm_write_ready.
  - mm_wdata = src_data, combinational pass-through with zero latency.
- Row counter wr_cnt counts transfers. LOAD_A -> LOAD_B after MATRIX_WIDTH transfers. LOAD_B -> DRAIN after the next MATRIX_WIDTH transfers. The counter resets at each transition.
- DRAIN:
  - mm_read_en = DRAIN && rd_cnt < MATRIX_WIDTH && (!res_valid || res_ready).
  - mm_rdata is sampled in the cycle where mm_read_en && mm_read_ready hold. On that edge res_data <= mm_rdata and res_valid <= 1.
  - res_last <= 1 when this is read number MATRIX_WIDTH-1 (zero-based).
  - rd_cnt increments on each read handshake.
- Output register: a read and a downstream accept in the same cycle reload the register back-to-back. This sustains one row per cycle.
  - An accept with no read clears res_valid and res_last.
  - res_data holds its value while res_valid && !res_ready.
- DRAIN -> FIN when the last row (res_last) is accepted downstream.
- FIN: done = 1 for one cycle, busy = 0, then IDLE.
- busy = 1 in LOAD_A, LOAD_B, DRAIN. It is registered with the state, so it rises the cycle after start.
- Upstream stalls: src_valid low or mm_write_ready low inserts idle cycles; row ordering is preserved. Multiplier stalls (mm_read_ready low) likewise hold rd_cnt.
- No data width change: rows are transferred unmodified in both directions.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, LOAD_A=1, LOAD_B=2, DRAIN=3, FIN=4);
  - ROW_BITS = NUM_ELEMENTS*WIDTH;
  - CNT_BITS = clog2(MATRIX_WIDTH+1).
- One natural sub-module: lmm_result_skid, the single-entry valid/ready output register with its last flag. The FSM and counters stay in the top.

Test Plan:
- Basic job: reset 2 cycles, start, src feeds A rows 1..4, B rows 5..8, ready always high. Required: exactly 8 mm_write_en cycles with wdata 1..8 in order. Multiplier model returns 0x11,0x22,0x33,0x44. res_data follows the same sequence on 4 consecutive valid cycles, res_last only on 0x44. done pulses once.
- Write backpressure: mm_write_ready toggles 1,0,1,0. Required: src_ready mirrors it, no row is duplicated or dropped, 8 transfers total, LOAD_B is entered after the 4th.
- Downstream stall: res_ready low for 5 cycles on the 2nd result. Required: res_data holds 0x22 and mm_read_en stays low. On release, 0x33 and 0x44 follow back-to-back.
- Start while busy: pulse start during LOAD_B and DRAIN. Required: no restart, counters unchanged, single done.
- Reset mid-DRAIN after 2 rows read. Required: next cycle all outputs 0, state IDLE. A fresh job then completes normally with 4 result rows.
- Idle source: start with src_valid low for 10 cycles. Required: mm_write_en stays 0 and busy stays 1; the job completes when rows arrive.
